// File: rtl/redirect_ctrl.sv
// Control-flow redirect controller: captures taken branches and traps, hands the
// new PC to fetch over valid/ready, then holds flush for a configurable drain.
module redirect_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_valid_i,
  input  logic             ex_branch_i,
  input  logic             ex_taken_i,
  input  logic [31:0]      ex_target_i,
  input  logic             trap_i,
  input  logic [31:0]      trap_pc_i,
  output logic             trap_ack_o,
  output logic             redirect_valid_o,
  output logic [31:0]      redirect_pc_o,
  input  logic             redirect_ready_i,
  output logic             flush_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    DRAIN    = 2'd2
  } state_t;

  localparam logic [2:0] DRAIN_LOAD = (FLUSH_CYCLES == 0) ? 3'd0 : 3'(FLUSH_CYCLES - 1);

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [2:0]       r_drain;
  logic             r_trap_ack;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_redirect_cnt;

  logic w_count_br;
  logic w_handshake;

  assign w_count_br  = (r_state == IDLE) && ex_valid_i && ex_branch_i && !trap_i;
  assign w_handshake = (r_state == REDIRECT) && redirect_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state        <= IDLE;
      r_pc           <= '0;
      r_drain        <= '0;
      r_trap_ack     <= 1'b0;
      r_branch_cnt   <= '0;
      r_redirect_cnt <= '0;
    end else begin
      r_trap_ack <= 1'b0;

      if (w_count_br && (r_branch_cnt != '1))
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if (w_handshake && (r_redirect_cnt != '1))
        r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);

      case (r_state)
        IDLE: begin
          if (trap_i) begin
            r_pc       <= trap_pc_i;
            r_trap_ack <= 1'b1;
            r_state    <= REDIRECT;
          end else if (ex_valid_i && ex_taken_i) begin
            r_pc    <= ex_target_i;
            r_state <= REDIRECT;
          end
        end
        REDIRECT: begin
          // A pending trap waits here; it is picked up once back in IDLE or DRAIN.
          if (redirect_ready_i) begin
            if (FLUSH_CYCLES == 0) begin
              r_state <= IDLE;
            end else begin
              r_drain <= DRAIN_LOAD;
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (trap_i) begin
            r_pc       <= trap_pc_i;
            r_trap_ack <= 1'b1;
            r_state    <= REDIRECT;
          end else if (r_drain == '0) begin
            r_state <= IDLE;
          end else begin
            r_drain <= r_drain - 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Outside IDLE flush is always 1; in IDLE it marks the capture cycle.
  assign flush_o          = (r_state != IDLE) || trap_i || (ex_valid_i && ex_taken_i);
  assign redirect_valid_o = (r_state == REDIRECT);
  assign stall_o          = (r_state == REDIRECT);
  assign redirect_pc_o    = r_pc;
  assign trap_ack_o       = r_trap_ack;
  assign branch_cnt_o     = r_branch_cnt;
  assign redirect_cnt_o   = r_redirect_cnt;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Bench for redirect_ctrl: vector table of redirect transactions plus hand-built
// sequences for backpressure, trap-in-window, reset mid-redirect and saturation.
module tb_redirect_ctrl;

  localparam int unsigned FC  = 2;
  localparam int unsigned CW  = 4;
  localparam int unsigned SAT = 15;

  logic          clk;
  logic          rst_i;
  logic          ex_valid_i, ex_branch_i, ex_taken_i;
  logic [31:0]   ex_target_i;
  logic          trap_i;
  logic [31:0]   trap_pc_i;
  logic          trap_ack_o;
  logic          redirect_valid_o;
  logic [31:0]   redirect_pc_o;
  logic          redirect_ready_i;
  logic          flush_o, stall_o;
  logic [CW-1:0] branch_cnt_o, redirect_cnt_o;

  redirect_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .ex_valid_i(ex_valid_i), .ex_branch_i(ex_branch_i), .ex_taken_i(ex_taken_i),
    .ex_target_i(ex_target_i), .trap_i(trap_i), .trap_pc_i(trap_pc_i),
    .trap_ack_o(trap_ack_o), .redirect_valid_o(redirect_valid_o),
    .redirect_pc_o(redirect_pc_o), .redirect_ready_i(redirect_ready_i),
    .flush_o(flush_o), .stall_o(stall_o),
    .branch_cnt_o(branch_cnt_o), .redirect_cnt_o(redirect_cnt_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        br;
    logic        tk;
    logic [31:0] tgt;
    logic        trap;
    logic [31:0] tvec;
    int unsigned wait_n;
    logic        redir;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t        vecs[7];
  logic [31:0] sb[$];
  int          n_cmp = 0;
  int          n_mis = 0;
  int unsigned exp_b = 0;
  int unsigned exp_r = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= SAT) ? SAT : v + 1;
  endfunction

  task automatic chk_cnts(input string nm);
    chk({nm, "_branch_cnt"}, 32'(branch_cnt_o), exp_b);
    chk({nm, "_redirect_cnt"}, 32'(redirect_cnt_o), exp_r);
  endtask

  // Scoreboard: every completed handshake must present the oldest expected PC.
  always @(negedge clk) begin
    #2;
    if (!rst_i && redirect_valid_o && redirect_ready_i) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL sb_unexpected: handshake pc 0x%08h, expected none at %0t", redirect_pc_o, $time);
      end else begin
        automatic logic [31:0] e = sb.pop_front();
        if (redirect_pc_o !== e) begin
          n_mis++;
          $display("FAIL sb_pc: got 0x%08h expected 0x%08h at %0t", redirect_pc_o, e, $time);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v, input bit sync);
    if (sync) @(negedge clk);
    ex_valid_i = 1'b1; ex_branch_i = v.br; ex_taken_i = v.tk; ex_target_i = v.tgt;
    trap_i = v.trap; trap_pc_i = v.tvec; redirect_ready_i = 1'b0;
    if (v.br && !v.trap) exp_b = sat_inc(exp_b);
    if (v.redir) sb.push_back(v.exp_pc);
    #1;
    chk("cap_flush", 32'(flush_o), 32'(v.redir));
    chk("cap_valid", 32'(redirect_valid_o), 0);
    @(negedge clk);
    ex_valid_i = 1'b0; ex_branch_i = 1'b0; ex_taken_i = 1'b0;
    if (v.redir) begin
      for (int unsigned k = 0; k <= v.wait_n; k++) begin
        redirect_ready_i = (k == v.wait_n);
        #1;
        chk("rd_valid", 32'(redirect_valid_o), 1);
        chk("rd_stall", 32'(stall_o), 1);
        chk("rd_flush", 32'(flush_o), 1);
        chk("rd_pc", redirect_pc_o, v.exp_pc);
        chk("rd_ack", 32'(trap_ack_o), 32'(v.trap && k == 0));
        @(negedge clk);
        trap_i = 1'b0;
      end
      redirect_ready_i = 1'b0;
      exp_r = sat_inc(exp_r);
      for (int unsigned k = 0; k < FC; k++) begin
        #1;
        chk("dr_flush", 32'(flush_o), 1);
        chk("dr_stall", 32'(stall_o), 0);
        chk("dr_valid", 32'(redirect_valid_o), 0);
        @(negedge clk);
      end
    end
    trap_i = 1'b0;
    #1;
    chk("idle_flush", 32'(flush_o), 0);
    chk("idle_valid", 32'(redirect_valid_o), 0);
    chk_cnts("vec");
  endtask

  initial begin
    automatic vec_t jv;
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    automatic vec_t jv;
    vecs[0] = '{br:1'b1, tk:1'b1, tgt:32'h0000_0100, trap:1'b0, tvec:32'h0, wait_n:0, redir:1'b1, exp_pc:32'h0000_0100};
    vecs[1] = '{br:1'b1, tk:1'b0, tgt:32'h0000_0140, trap:1'b0, tvec:32'h0, wait_n:0, redir:1'b0, exp_pc:32'h0};
    vecs[2] = '{br:1'b1, tk:1'b0, tgt:32'h0000_0180, trap:1'b0, tvec:32'h0, wait_n:0, redir:1'b0, exp_pc:32'h0};
    vecs[3] = '{br:1'b1, tk:1'b0, tgt:32'h0000_01C0, trap:1'b0, tvec:32'h0, wait_n:0, redir:1'b0, exp_pc:32'h0};
    vecs[4] = '{br:1'b1, tk:1'b1, tgt:32'h0000_0200, trap:1'b1, tvec:32'h8000_0000, wait_n:0, redir:1'b1, exp_pc:32'h8000_0000};
    vecs[5] = '{br:1'b0, tk:1'b1, tgt:32'h0000_0400, trap:1'b0, tvec:32'h0, wait_n:5, redir:1'b1, exp_pc:32'h0000_0400};
    vecs[6] = '{br:1'b1, tk:1'b1, tgt:32'h0000_1234, trap:1'b0, tvec:32'h0, wait_n:2, redir:1'b1, exp_pc:32'h0000_1234};

    rst_i = 1'b1; ex_valid_i = 1'b0; ex_branch_i = 1'b0; ex_taken_i = 1'b0;
    ex_target_i = '0; trap_i = 1'b0; trap_pc_i = '0; redirect_ready_i = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 32'(redirect_valid_o), 0);
    chk("rst_stall", 32'(stall_o), 0);
    chk("rst_ack", 32'(trap_ack_o), 0);
    chk("rst_pc", redirect_pc_o, 0);
    chk_cnts("rst");

    // First vector is driven in the same cycle reset is released.
    @(negedge clk);
    rst_i = 1'b0;
    run_vec(vecs[0], 1'b0);
    for (int i = 1; i < 7; i++) run_vec(vecs[i], 1'b1);

    // Backpressure with EX still asserting, and a trap raised inside the window.
    @(negedge clk);
    ex_valid_i = 1'b1; ex_branch_i = 1'b1; ex_taken_i = 1'b1; ex_target_i = 32'h0000_0ABC;
    exp_b = sat_inc(exp_b);
    sb.push_back(32'h0000_0ABC);
    #1 chk("bp_cap_flush", 32'(flush_o), 1);
    @(negedge clk);
    ex_target_i = 32'h0000_0555;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_valid", 32'(redirect_valid_o), 1);
      chk("bp_stall", 32'(stall_o), 1);
      chk("bp_pc", redirect_pc_o, 32'h0000_0ABC);
      chk("bp_ack", 32'(trap_ack_o), 0);
      if (k == 1) begin
        trap_i = 1'b1; trap_pc_i = 32'hC0DE_0000;
      end
      @(negedge clk);
    end
    redirect_ready_i = 1'b1;
    #1;
    chk("bp_hs_valid", 32'(redirect_valid_o), 1);
    chk("bp_hs_ack", 32'(trap_ack_o), 0);
    exp_r = sat_inc(exp_r);
    @(negedge clk);
    redirect_ready_i = 1'b0;
    sb.push_back(32'hC0DE_0000);
    #1;
    chk("bp_drain_flush", 32'(flush_o), 1);
    chk("bp_drain_stall", 32'(stall_o), 0);
    chk("bp_drain_ack", 32'(trap_ack_o), 0);
    @(negedge clk);
    redirect_ready_i = 1'b1;
    #1;
    chk("tr_ack", 32'(trap_ack_o), 1);
    chk("tr_valid", 32'(redirect_valid_o), 1);
    chk("tr_pc", redirect_pc_o, 32'hC0DE_0000);
    exp_r = sat_inc(exp_r);
    @(negedge clk);
    trap_i = 1'b0; redirect_ready_i = 1'b0;
    for (int unsigned k = 0; k < FC; k++) begin
      #1;
      chk("tr_dr_flush", 32'(flush_o), 1);
      chk("tr_dr_ack", 32'(trap_ack_o), 0);
      @(negedge clk);
    end
    ex_valid_i = 1'b0; ex_branch_i = 1'b0; ex_taken_i = 1'b0;
    #1;
    chk("tr_idle_flush", 32'(flush_o), 0);
    chk_cnts("bp");

    // Reset in the middle of a redirect, then an immediate new capture.
    @(negedge clk);
    ex_valid_i = 1'b1; ex_branch_i = 1'b1; ex_taken_i = 1'b1; ex_target_i = 32'h0000_0F00;
    @(negedge clk);
    ex_valid_i = 1'b0; ex_branch_i = 1'b0; ex_taken_i = 1'b0;
    #1;
    chk("mr_valid_pre", 32'(redirect_valid_o), 1);
    rst_i = 1'b1;
    #1;
    exp_b = 0; exp_r = 0;
    sb.delete();
    chk("mr_valid", 32'(redirect_valid_o), 0);
    chk("mr_stall", 32'(stall_o), 0);
    chk("mr_pc", redirect_pc_o, 0);
    chk_cnts("mr");
    @(negedge clk);
    rst_i = 1'b0;
    jv = '{br:1'b1, tk:1'b1, tgt:32'h0000_0300, trap:1'b0, tvec:32'h0, wait_n:0, redir:1'b1, exp_pc:32'h0000_0300};
    run_vec(jv, 1'b0);

    // Back-to-back not-taken branches drive the branch counter into saturation.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ex_valid_i = 1'b1; ex_branch_i = 1'b1; ex_taken_i = 1'b0;
      exp_b = sat_inc(exp_b);
      @(posedge clk);
      #1 chk("sat_branch_cnt", 32'(branch_cnt_o), exp_b);
    end
    @(negedge clk);
    ex_valid_i = 1'b0; ex_branch_i = 1'b0;

    jv = '{br:1'b0, tk:1'b1, tgt:32'h0000_0800, trap:1'b0, tvec:32'h0, wait_n:0, redir:1'b1, exp_pc:32'h0000_0800};
    for (int i = 0; i < 16; i++) run_vec(jv, 1'b1);
    chk("sat_redirect_cnt", 32'(redirect_cnt_o), SAT);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
